// File: rtl/k12a_spi_master_pkg.sv
// Shared types and constants for the k12a SPI master: FSM states, register map, CTRL bit positions.
// No logic; imported by the interface, the clock generator and the top.
package k12a_spi_master_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_LEAD  = 2'd1,
    SPI_SHIFT = 2'd2,
    SPI_TRAIL = 2'd3
  } spi_state_t;

  localparam logic [1:0] SPI_REG_DATA   = 2'd0;
  localparam logic [1:0] SPI_REG_CTRL   = 2'd1;
  localparam logic [1:0] SPI_REG_DIV    = 2'd2;
  localparam logic [1:0] SPI_REG_STATUS = 2'd3;

  localparam int CTRL_CPOL      = 0;
  localparam int CTRL_CPHA      = 1;
  localparam int CTRL_LSB_FIRST = 2;
  localparam int CTRL_CS_HOLD   = 3;
  localparam int CTRL_CS_SEL_LO = 4;
  localparam int CTRL_IRQ_EN    = 7;

endpackage

// File: rtl/k12a_spi_master_if.sv
// CPU register port plus SPI pins of the k12a SPI master. The slave modport is the peripheral's
// view (it answers register accesses); the master modport is the CPU/board side.
interface k12a_spi_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4
);
  logic [1:0]            reg_addr;
  logic                  reg_write;
  logic                  reg_read;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  spi_sck;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [NUM_CS-1:0]     spi_cs_n;
  logic                  wake;

  modport master (
    output reg_addr, reg_write, reg_read, reg_wdata, spi_miso,
    input  reg_rdata, spi_sck, spi_mosi, spi_cs_n, wake
  );

  modport slave (
    input  reg_addr, reg_write, reg_read, reg_wdata, spi_miso,
    output reg_rdata, spi_sck, spi_mosi, spi_cs_n, wake
  );
endinterface

// File: rtl/k12a_spi_master_clkgen.sv
// Half-period tick generator: down-counter reloaded from i_div, one-cycle tick every i_div+1 enabled cycles.
// i_load restarts the count so the first half-period of a transfer is always full length.
module k12a_spi_clkgen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);
  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load || (i_en && r_cnt == '0)) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);
endmodule

// File: rtl/k12a_spi_master.sv
// SPI master on the k12a I/O bus: DATA write starts a frame, busy for (2*DATA_WIDTH+2)*(DIV+1) cycles.
// No backpressure: a DATA write while busy is dropped and flags overrun.
module k12a_spi_master
  import k12a_spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                i_cpu_clock,
  input  logic                i_reset,
  k12a_spi_master_if.slave    bus
);
  localparam int HW = $clog2(2 * DATA_WIDTH);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_WIDTH - 1);

  spi_state_t            r_state, w_next;
  logic [7:0]            r_ctrl;
  logic [DIV_WIDTH-1:0]  r_div, r_div_wk;
  logic [DATA_WIDTH-1:0] r_rx, r_shift;
  logic [HW-1:0]         r_hcnt;
  logic                  r_done, r_overrun, r_mosi, r_sck;
  logic                  r_cpol_wk, r_cpha_wk, r_lsb_wk;
  logic [2:0]            r_cs_sel_wk;

  logic [7:0]            w_wdata8, w_rdata8;
  logic                  w_busy, w_start, w_wr_data, w_wr_status, w_tick, w_last;
  logic                  w_lead_edge, w_trail_edge, w_sample, w_drive, w_out_bit, w_idle_entry;
  logic [DATA_WIDTH-1:0] w_shift_in;
  logic [2:0]            w_cs_sel;
  logic                  w_cs_act;
  logic [NUM_CS-1:0]     w_cs_n;

  assign w_wdata8     = 8'(bus.reg_wdata);
  assign w_busy       = (r_state != SPI_IDLE);
  assign w_wr_data    = bus.reg_write && (bus.reg_addr == SPI_REG_DATA);
  assign w_wr_status  = bus.reg_write && (bus.reg_addr == SPI_REG_STATUS);
  assign w_start      = w_wr_data && !w_busy;
  assign w_last       = (r_hcnt == LAST_HALF);
  assign w_lead_edge  = w_tick && (r_state == SPI_SHIFT) && !r_hcnt[0];
  assign w_trail_edge = w_tick && (r_state == SPI_SHIFT) && r_hcnt[0];
  // cpha=0 has nothing left to drive after the final trailing edge, so mosi keeps the last bit.
  assign w_sample     = r_cpha_wk ? w_trail_edge : w_lead_edge;
  assign w_drive      = r_cpha_wk ? w_lead_edge : (w_trail_edge && !w_last);
  assign w_out_bit    = r_lsb_wk ? r_shift[0] : r_shift[DATA_WIDTH-1];
  assign w_shift_in   = r_lsb_wk ? {bus.spi_miso, r_shift[DATA_WIDTH-1:1]}
                                 : {r_shift[DATA_WIDTH-2:0], bus.spi_miso};
  assign w_idle_entry = w_tick && (r_state == SPI_TRAIL);

  k12a_spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .i_clk  (i_cpu_clock),
    .i_rst  (i_reset),
    .i_load (w_start),
    .i_en   (w_busy),
    .i_div  (w_start ? r_div : r_div_wk),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_cpu_clock or posedge i_reset) begin
    if (i_reset) r_state <= SPI_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SPI_IDLE:  if (w_start)           w_next = SPI_LEAD;
      SPI_LEAD:  if (w_tick)            w_next = SPI_SHIFT;
      SPI_SHIFT: if (w_tick && w_last)  w_next = SPI_TRAIL;
      SPI_TRAIL: if (w_tick)            w_next = SPI_IDLE;
      default:                          w_next = SPI_IDLE;
    endcase
  end

  always_ff @(posedge i_cpu_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl      <= '0;
      r_div       <= '0;
      r_div_wk    <= '0;
      r_rx        <= '0;
      r_shift     <= '0;
      r_hcnt      <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_mosi      <= 1'b0;
      r_sck       <= 1'b0;
      r_cpol_wk   <= 1'b0;
      r_cpha_wk   <= 1'b0;
      r_lsb_wk    <= 1'b0;
      r_cs_sel_wk <= '0;
    end else begin
      if (bus.reg_write && bus.reg_addr == SPI_REG_CTRL) r_ctrl <= w_wdata8;
      if (bus.reg_write && bus.reg_addr == SPI_REG_DIV)  r_div  <= w_wdata8[DIV_WIDTH-1:0];
      if (w_start) begin
        r_shift     <= bus.reg_wdata;
        r_hcnt      <= '0;
        r_cpol_wk   <= r_ctrl[CTRL_CPOL];
        r_cpha_wk   <= r_ctrl[CTRL_CPHA];
        r_lsb_wk    <= r_ctrl[CTRL_LSB_FIRST];
        r_cs_sel_wk <= r_ctrl[CTRL_CS_SEL_LO +: 3];
        r_div_wk    <= r_div;
        r_sck       <= r_ctrl[CTRL_CPOL];
        if (!r_ctrl[CTRL_CPHA])
          r_mosi <= r_ctrl[CTRL_LSB_FIRST] ? bus.reg_wdata[0] : bus.reg_wdata[DATA_WIDTH-1];
      end
      if (w_tick && r_state == SPI_SHIFT) begin
        r_sck  <= ~r_sck;
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_sample)     r_shift <= w_shift_in;
      if (w_drive)      r_mosi  <= w_out_bit;
      if (w_idle_entry) r_rx    <= r_shift;
      // Completion outranks any clear arriving in the same cycle.
      if (w_idle_entry)
        r_done <= 1'b1;
      else if ((bus.reg_read && bus.reg_addr == SPI_REG_DATA) || (w_wr_status && w_wdata8[1]))
        r_done <= 1'b0;
      if (w_wr_data && w_busy)
        r_overrun <= 1'b1;
      else if (w_wr_status && w_wdata8[2])
        r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_rdata8 = 8'h00;
    unique case (bus.reg_addr)
      SPI_REG_DATA:   w_rdata8 = 8'(r_rx);
      SPI_REG_CTRL:   w_rdata8 = r_ctrl;
      SPI_REG_DIV:    w_rdata8 = 8'(r_div);
      SPI_REG_STATUS: w_rdata8 = {5'b0, r_overrun, r_done, w_busy};
      default:        w_rdata8 = 8'h00;
    endcase
  end

  // Idle chip select follows live CTRL; during a frame the snapshot rules.
  always_comb begin
    w_cs_sel = w_busy ? r_cs_sel_wk : r_ctrl[CTRL_CS_SEL_LO +: 3];
    w_cs_act = w_busy || r_ctrl[CTRL_CS_HOLD];
    w_cs_n   = '1;
    for (int i = 0; i < NUM_CS; i++)
      w_cs_n[i] = !(w_cs_act && (int'(w_cs_sel) == i));
  end

  assign bus.reg_rdata = w_rdata8[DATA_WIDTH-1:0];
  assign bus.spi_sck   = w_busy ? r_sck : r_ctrl[CTRL_CPOL];
  assign bus.spi_mosi  = r_mosi;
  assign bus.spi_cs_n  = w_cs_n;
  assign bus.wake      = r_done && r_ctrl[CTRL_IRQ_EN];
endmodule

// File: tb/tb_k12a_spi_master.sv
// Scoreboard bench for k12a_spi_master: stimulus pushes expected register/pin values and SPI frames,
// a negedge monitor pops and compares them, and also acts as the SPI slave.
module tb_k12a_spi_master;
  import k12a_spi_master_pkg::*;

  localparam int SEL_RDATA = 0, SEL_CS = 1, SEL_SCK = 2, SEL_WAKE = 3;

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      nm;
  } obs_t;

  typedef struct {
    int         cyc;
    int         rises;
    logic [7:0] mosi;
    string      nm;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  k12a_spi_master_if #(.DATA_WIDTH(8), .NUM_CS(4)) bus ();

  k12a_spi_master #(.DATA_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) dut (
    .i_cpu_clock (clk),
    .i_reset     (rst),
    .bus         (bus)
  );

  obs_t   obs_q[$];
  frame_t frame_q[$];
  logic   obs_vld = 1'b0, end_req = 1'b0, end_ack = 1'b0;
  logic   loop = 1'b1, slv_bit = 1'b0, cur_cpol = 1'b0, cur_cpha = 1'b0;
  logic [7:0] slv_pat = 8'h3C;
  int n_checks = 0, n_errors = 0;

  always_comb bus.spi_miso = loop ? bus.spi_mosi : slv_bit;

  // Monitor / scoreboard / SPI slave
  logic prev_sck = 1'b0, prev_cs_low = 1'b0;
  int f_cyc = 0, f_edges = 0, f_rises = 0;
  logic [7:0] f_cap = 8'h00;

  task automatic cmp(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    obs_t o;
    frame_t f;
    logic [7:0] act;
    logic cs_low, lead;
    int k;
    cs_low = (bus.spi_cs_n != 4'hF);
    if (obs_vld && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      case (o.sel)
        SEL_RDATA: act = bus.reg_rdata;
        SEL_CS:    act = {4'h0, bus.spi_cs_n};
        SEL_SCK:   act = {7'h0, bus.spi_sck};
        default:   act = {7'h0, bus.wake};
      endcase
      cmp(o.nm, int'(act), int'(o.exp));
    end
    if (cs_low) begin
      if (!prev_cs_low) begin
        f_cyc = 1; f_edges = 0; f_rises = 0; f_cap = 8'h00;
      end else begin
        f_cyc++;
        if (bus.spi_sck != prev_sck) begin
          f_edges++;
          if (bus.spi_sck) f_rises++;
          lead = (bus.spi_sck != cur_cpol);
          if (lead != cur_cpha) f_cap = {f_cap[6:0], bus.spi_mosi};
        end
      end
    end else if (prev_cs_low && frame_q.size() > 0) begin
      f = frame_q.pop_front();
      cmp({f.nm, " busy_cycles"}, f_cyc, f.cyc);
      cmp({f.nm, " sck_rises"}, f_rises, f.rises);
      cmp({f.nm, " mosi_bits"}, int'(f_cap), int'(f.mosi));
    end
    k = cur_cpha ? ((f_edges == 0) ? 0 : (f_edges - 1) / 2) : f_edges / 2;
    if (k > 7) k = 7;
    slv_bit = slv_pat[7 - k];
    prev_sck = bus.spi_sck;
    prev_cs_low = cs_low;
    if (end_req && !end_ack) begin
      cmp("obs_queue_drained", obs_q.size(), 0);
      cmp("frame_queue_drained", frame_q.size(), 0);
      end_ack = 1'b1;
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_write = 1'b1;
    tick();
    bus.reg_write = 1'b0;
  endtask

  task automatic chk(input int sel, input logic [7:0] exp, input string nm);
    obs_q.push_back('{sel: sel, exp: exp, nm: nm});
    obs_vld = 1'b1;
    tick();
    obs_vld = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm, input bit strobe = 0);
    bus.reg_addr = a;
    bus.reg_read = strobe;
    chk(SEL_RDATA, exp, nm);
    bus.reg_read = 1'b0;
  endtask

  task automatic expect_frame(input int cyc, input logic [7:0] mosi, input string nm);
    frame_q.push_back('{cyc: cyc, rises: 8, mosi: mosi, nm: nm});
  endtask

  task automatic wait_idle();
    bus.reg_addr = SPI_REG_STATUS;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.reg_rdata[0] == 1'b0) break;
    end
    tick();
  endtask

  initial begin
    bus.reg_addr = 2'd0; bus.reg_write = 1'b0; bus.reg_read = 1'b0; bus.reg_wdata = 8'h00;
    repeat (2) tick();
    chk(SEL_CS, 8'h0F, "reset_cs_n");
    chk(SEL_SCK, 8'h00, "reset_sck");
    chk(SEL_WAKE, 8'h00, "reset_wake");
    rst = 1'b0;
    tick();
    rd(SPI_REG_STATUS, 8'h00, "reset_status");
    rd(SPI_REG_DATA, 8'h00, "reset_data");
    rd(SPI_REG_CTRL, 8'h00, "reset_ctrl");

    // Loopback, mode 0, DIV=0
    wr(SPI_REG_DIV, 8'h00);
    wr(SPI_REG_CTRL, 8'h00);
    loop = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b0;
    expect_frame(18, 8'hA5, "loop_a5");
    wr(SPI_REG_DATA, 8'hA5);
    chk(SEL_CS, 8'h0E, "loop_cs_active");
    rd(SPI_REG_STATUS, 8'h01, "loop_busy");
    wait_idle();
    rd(SPI_REG_STATUS, 8'h02, "loop_done");
    chk(SEL_CS, 8'h0F, "loop_cs_released");
    chk(SEL_WAKE, 8'h00, "wake_irq_off");
    rd(SPI_REG_DATA, 8'hA5, "loop_rx", 1);
    rd(SPI_REG_STATUS, 8'h00, "done_cleared_by_read");

    // Mode sweep with slave returning 8'h3C
    wr(SPI_REG_DIV, 8'h03);
    rd(SPI_REG_DIV, 8'h03, "div_readback");
    loop = 1'b0; slv_pat = 8'h3C;
    for (int m = 0; m < 4; m++) begin
      logic [7:0] cv;
      cv = 8'(m);
      wr(SPI_REG_CTRL, cv);
      cur_cpol = cv[0]; cur_cpha = cv[1];
      chk(SEL_SCK, {7'h0, cv[0]}, $sformatf("mode%0d_sck_idle", m));
      expect_frame(72, 8'h96, $sformatf("mode%0d", m));
      wr(SPI_REG_DATA, 8'h96);
      wait_idle();
      rd(SPI_REG_DATA, 8'h3C, $sformatf("mode%0d_rx", m), 1);
    end

    // LSB first
    wr(SPI_REG_DIV, 8'h00);
    wr(SPI_REG_CTRL, 8'h04);
    loop = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b0;
    expect_frame(18, 8'h80, "lsb_first");
    wr(SPI_REG_DATA, 8'h01);
    wait_idle();
    rd(SPI_REG_DATA, 8'h01, "lsb_rx", 1);

    // Overrun
    wr(SPI_REG_CTRL, 8'h00);
    expect_frame(18, 8'hC3, "overrun_frame");
    wr(SPI_REG_DATA, 8'hC3);
    repeat (4) tick();
    wr(SPI_REG_DATA, 8'h11);
    wait_idle();
    rd(SPI_REG_STATUS, 8'h06, "overrun_status");
    rd(SPI_REG_DATA, 8'hC3, "overrun_rx");
    wr(SPI_REG_STATUS, 8'h07);
    rd(SPI_REG_STATUS, 8'h00, "status_w1c");

    // CS hold across frames, then an out-of-range select
    wr(SPI_REG_CTRL, 8'h28);
    rd(SPI_REG_CTRL, 8'h28, "ctrl_readback");
    chk(SEL_CS, 8'h0B, "hold_cs_idle");
    wr(SPI_REG_DATA, 8'h5A);
    wait_idle();
    chk(SEL_CS, 8'h0B, "hold_cs_between");
    wr(SPI_REG_DATA, 8'h66);
    chk(SEL_CS, 8'h0B, "hold_cs_second");
    wait_idle();
    rd(SPI_REG_DATA, 8'h66, "hold_rx");
    wr(SPI_REG_CTRL, 8'h58);
    chk(SEL_CS, 8'h0F, "cs_sel5_idle");
    wr(SPI_REG_DATA, 8'h77);
    chk(SEL_CS, 8'h0F, "cs_sel5_busy");
    wait_idle();
    rd(SPI_REG_DATA, 8'h77, "cs_sel5_rx");

    // Reset mid-SHIFT
    wr(SPI_REG_CTRL, 8'h00);
    wr(SPI_REG_DATA, 8'h81);
    repeat (5) tick();
    chk(SEL_WAKE, 8'h00, "wake_busy_irq_off");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(SPI_REG_STATUS, 8'h00, "midreset_status");
    chk(SEL_CS, 8'h0F, "midreset_cs_n");
    chk(SEL_SCK, 8'h00, "midreset_sck");
    rd(SPI_REG_DATA, 8'h00, "midreset_rx");

    // Wake with irq_en
    wr(SPI_REG_CTRL, 8'h80);
    expect_frame(18, 8'h81, "irq_frame");
    wr(SPI_REG_DATA, 8'h81);
    chk(SEL_WAKE, 8'h00, "wake_before_done");
    wait_idle();
    chk(SEL_WAKE, 8'h01, "wake_after_done");
    rd(SPI_REG_DATA, 8'h81, "irq_rx", 1);
    chk(SEL_WAKE, 8'h00, "wake_cleared");

    end_req = 1'b1;
    for (int i = 0; i < 20 && !end_ack; i++) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end
endmodule
